// File: rtl/saph_num_pack.sv
// saph_num_pack: variable-width number packer.
// Each input number is truncated to its top w bits (w = min(in_width, pack_width))
// and packed densely, LSB-first, into word_width-bit output words. A last element
// closes the stream: the partial word is emitted with out_last, and a last element
// that overflows the current word takes one extra FLUSH cycle for its remainder.
module saph_num_pack #(
  parameter  int pack_width   = 8,
  parameter  int unpack_width = 8,
  parameter  int word_width   = 32,
  localparam int pack_exp     = $clog2(pack_width + 1),
  localparam int cnt_w        = $clog2(word_width + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [unpack_width-1:0] in_data,
  input  logic [pack_exp-1:0]     in_width,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [word_width-1:0]   out_data,
  output logic [cnt_w-1:0]        out_bits,
  output logic                    out_last
);

  // Accumulator holds up to word_width-1 pending bits plus one full element.
  localparam int ACC_W = word_width + pack_width - 1;
  // count + w can reach word_width + pack_width - 1, so one extra bit suffices.
  localparam int SUM_W = cnt_w + 1;
  localparam int EXT_W = (ACC_W > unpack_width) ? ACC_W : unpack_width;

  localparam logic [pack_exp-1:0] PW_MAX  = pack_exp'(pack_width);
  localparam logic [SUM_W-1:0]    WW_SUM  = SUM_W'(word_width);
  localparam logic [cnt_w-1:0]    WW_BITS = cnt_w'(word_width);

  typedef enum logic {
    S_RUN,
    S_FLUSH
  } state_e;

  state_e                  state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [cnt_w-1:0]        count_q, count_d;
  logic                    out_valid_q, out_valid_d;
  logic [word_width-1:0]   out_data_q, out_data_d;
  logic [cnt_w-1:0]        out_bits_q, out_bits_d;
  logic                    out_last_q, out_last_d;

  logic [pack_exp-1:0]     w_eff;
  int                      shamt;
  logic [unpack_width-1:0] trunc;
  logic [EXT_W-1:0]        val_wide;
  logic [ACC_W-1:0]        placed;
  logic [ACC_W-1:0]        new_acc;
  logic [ACC_W-1:0]        acc_rem;
  logic [SUM_W-1:0]        sum;
  logic [SUM_W-1:0]        rem;
  logic                    out_free;
  logic                    xfer;

  // Element decode: clamp width, keep the top w bits, place them at bit count.
  always_comb begin
    w_eff    = (in_width > PW_MAX) ? PW_MAX : in_width;
    // Shifting right by unpack_width-w leaves exactly the top w bits (none for w=0).
    shamt    = unpack_width - int'(w_eff);
    trunc    = in_data >> shamt;
    val_wide = EXT_W'(trunc);
    placed   = val_wide[ACC_W-1:0] << count_q;
    // Bits at and above count are always zero, so OR is a plain append.
    new_acc  = acc_q | placed;
    acc_rem  = new_acc >> word_width;
    sum      = SUM_W'(count_q) + SUM_W'(w_eff);
    rem      = sum - WW_SUM;
  end

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == S_RUN) && out_free;
  assign xfer     = in_valid && in_ready;

  // Next-state: packing, word emission, flush sequencing and output register.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_bits_d  = out_bits_q;
    out_last_d  = out_last_q;

    // A taken (or empty) output slot drops valid unless something new lands below.
    if (out_free) out_valid_d = 1'b0;

    case (state_q)
      S_RUN: begin
        if (xfer) begin
          if (sum < WW_SUM) begin
            if (in_last) begin
              // Partial (possibly empty) final word.
              out_valid_d = 1'b1;
              out_data_d  = new_acc[word_width-1:0];
              out_bits_d  = sum[cnt_w-1:0];
              out_last_d  = 1'b1;
              acc_d       = '0;
              count_d     = '0;
            end else begin
              acc_d   = new_acc;
              count_d = sum[cnt_w-1:0];
            end
          end else begin
            // Word filled; the spill-over becomes the new accumulator contents.
            out_valid_d = 1'b1;
            out_data_d  = new_acc[word_width-1:0];
            out_bits_d  = WW_BITS;
            out_last_d  = in_last && (rem == '0);
            acc_d       = acc_rem;
            count_d     = rem[cnt_w-1:0];
            if (in_last && (rem != '0)) state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // Remainder is narrower than pack_width, so it fits one word.
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_q[word_width-1:0];
          out_bits_d  = count_q;
          out_last_d  = 1'b1;
          acc_d       = '0;
          count_d     = '0;
          state_d     = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // State and output registers; reset drops any pending word and partial bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_bits_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_bits_q  <= out_bits_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_bits  = out_bits_q;
  assign out_last  = out_last_q;

endmodule
